// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and helpers for the ALU and its sequencer
//
// Contents:
//   OP_*        ALU opcode constants; OP_LAST is the highest legal code
//   ST_*        alu_sequencer FSM state encoding
//   ERR_DATA    response data returned for rejected commands
//   is_legal_op returns 1 for opcodes the ALU implements
package alu_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [1:0] state_t;

  localparam opcode_t OP_ADD    = 4'd0;
  localparam opcode_t OP_SUB    = 4'd1;
  localparam opcode_t OP_MULT   = 4'd2;
  localparam opcode_t OP_DIV    = 4'd3;
  localparam opcode_t OP_AND    = 4'd4;
  localparam opcode_t OP_OR     = 4'd5;
  localparam opcode_t OP_NAND   = 4'd6;
  localparam opcode_t OP_NOR    = 4'd7;
  localparam opcode_t OP_XOR    = 4'd8;
  localparam opcode_t OP_SHIFTR = 4'd9;
  localparam opcode_t OP_SHIFTL = 4'd10;
  localparam opcode_t OP_COMP   = 4'd11;
  localparam opcode_t OP_LAST   = OP_COMP;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  localparam logic [8:0] ERR_DATA = 9'h1FF;

  function automatic logic is_legal_op(input opcode_t op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x 8-bit register file, two async read ports, one sync write port
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears all registers)
//   we, waddr, wdata  synchronous write port
//   raddr_a, rdata_a  asynchronous read port A
//   raddr_b, rdata_b  asynchronous read port B
module alu_regfile #(
  parameter int NREG = 4,
  parameter int SELW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [SELW-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [SELW-1:0] raddr_a,
  output logic [7:0]      rdata_a,
  input  logic [SELW-1:0] raddr_b,
  output logic [7:0]      rdata_b
);

  logic [7:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 8'd0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command front-end that issues register-to-register ops to an external ALU
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*       command handshake and fields (op, dst, src_a, src_b, imm)
//   alu_opcode, alu_a, alu_b         registered operands driven to the ALU
//   alu_res, alu_carry, alu_zero     combinational ALU results
//   rsp_valid/rsp_ready, rsp_*       response handshake, captured result, flags and error
//   flag_carry, flag_zero            sticky flags from the last successful op
//   busy                             FSM is not idle
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NREG       = 4,
  parameter bit RSP_ON_ERR = 1'b1,
  localparam int SELW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [SELW-1:0] cmd_dst,
  input  logic [SELW-1:0] cmd_src_a,
  input  logic [SELW-1:0] cmd_src_b,
  input  logic            cmd_use_imm,
  input  logic [7:0]      cmd_imm,
  output logic [3:0]      alu_opcode,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [8:0]      alu_res,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [8:0]      rsp_data,
  output logic            rsp_carry,
  output logic            rsp_zero,
  output logic            rsp_err,
  output logic            flag_carry,
  output logic            flag_zero,
  output logic            busy
);

  state_t          state;
  logic [SELW-1:0] dst_q;
  logic [7:0]      rd_a;
  logic [7:0]      rd_b;
  logic [7:0]      opnd_b;
  logic            accept;
  logic            bad_cmd;
  logic            wb_en;

  // Writeback happens on the edge that ends ISSUE, so any command accepted
  // later (earliest: after RESP) already sees the updated register.
  assign wb_en = (state == ST_ISSUE);

  alu_regfile #(
    .NREG (NREG),
    .SELW (SELW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (dst_q),
    .wdata   (alu_res[7:0]),
    .raddr_a (cmd_src_a),
    .rdata_a (rd_a),
    .raddr_b (cmd_src_b),
    .rdata_b (rd_b)
  );

  assign opnd_b    = cmd_use_imm ? cmd_imm : rd_b;
  assign accept    = cmd_valid && cmd_ready;
  assign bad_cmd   = !is_legal_op(cmd_op) || ((cmd_op == OP_DIV) && (opnd_b == 8'd0));
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // cmd_ready is a flop so that it reads 0 while in reset and rises on the
  // first edge after release (or after the response handshake).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b0;
      dst_q      <= '0;
      alu_opcode <= 4'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      rsp_data   <= 9'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && bad_cmd) begin
            // Rejected commands never reach the ALU, so alu_* keep their values.
            if (RSP_ON_ERR) begin
              state     <= ST_RESP;
              cmd_ready <= 1'b0;
              rsp_data  <= ERR_DATA;
              rsp_carry <= 1'b0;
              rsp_zero  <= 1'b0;
              rsp_err   <= 1'b1;
            end else begin
              cmd_ready <= 1'b1;
            end
          end else if (accept) begin
            state      <= ST_ISSUE;
            cmd_ready  <= 1'b0;
            dst_q      <= cmd_dst;
            alu_opcode <= cmd_op;
            alu_a      <= rd_a;
            alu_b      <= opnd_b;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state      <= ST_RESP;
          rsp_data   <= alu_res;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
          flag_carry <= alu_carry;
          flag_zero  <= alu_zero;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
